// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch and sequencing stage of the accumulator CPU.
// Holds PC and IR, fetches over a rd/valid handshake, issues a one-cycle execute
// strobe, and selects the next PC (sequential, jump, taken BAN) or halts.
module fetch_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              imem_valid,
    output logic [3:0]        ins,
    output logic [ADDR_W-1:0] oper_addr,
    input  logic              stp,
    input  logic              pcWR,
    input  logic              acc_neg,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    // The opcode and operand fields must not overlap inside the instruction word.
    if (DATA_W < ADDR_W + 4) begin : g_bad_width
        $error("fetch_sequencer: DATA_W must be at least ADDR_W+4");
    end

    localparam logic [3:0] OP_BAN = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              imem_rd_q, imem_rd_d;
    logic              exec_en_q, exec_en_d;
    logic              halted_q, halted_d;

    // Fields decoded straight from the IR; bits between opcode and operand are don't-care.
    assign ins       = ir_q[DATA_W-1 -: 4];
    assign oper_addr = ir_q[ADDR_W-1:0];
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign imem_rd   = imem_rd_q;
    assign exec_en   = exec_en_q;
    assign halted    = halted_q;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[DATA_W-5:0];

    // Next-state, next-PC and IR-load selection; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Halt beats any jump and leaves the PC on the STP word.
                if (stp) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if (pcWR) begin
                        pc_d = oper_addr;
                    end else if ((ins == OP_BAN) && acc_neg) begin
                        pc_d = oper_addr;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        imem_rd_d = (state_d == ST_FETCH);
        exec_en_d = (state_d == ST_EXEC);
        halted_d  = (state_d == ST_HALT);
    end

    // State, PC, IR and registered control outputs; reset aborts any fetch or execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            imem_rd_q <= 1'b0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imem_rd_q <= imem_rd_d;
            exec_en_q <= exec_en_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and sequencing stage of the accumulator CPU. It sits directly upstream of the control-unit decoder.
- Holds the PC and the instruction register (IR), and reads instruction words from instruction memory over a rd/valid handshake.
- Presents the 4-bit opcode to the decoder. Issues a one-cycle execute strobe that qualifies the decoder's write enables.
- Consumes the decoder's stp and pcWR, plus the accumulator sign for BAN, to choose the next PC or to halt.

Parameters:
- ADDR_W, 8, instruction/data address width; PC width.
- DATA_W, 16, instruction word width. Opcode = IR[DATA_W-1 -: 4]; operand address = IR[ADDR_W-1:0]. Requires DATA_W >= ADDR_W+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; start fetching from IDLE.
- imem_addr  out  ADDR_W  instruction memory address (= PC).
- imem_rd  out  1  read request; held until accepted.
- imem_data  in  DATA_W  read data; valid when imem_valid=1.
- imem_valid  in  1  one-cycle read-complete pulse.
- ins  out  4  opcode to the decoder (= IR opcode field).
- oper_addr  out  ADDR_W  operand address to the datapath (= IR low field).
- stp  in  1  from the decoder: halt.
- pcWR  in  1  from the decoder: unconditional jump (JMP).
- acc_neg  in  1  accumulator MSB from the datapath.
- exec_en  out  1  one-cycle strobe; the datapath gates accWR/dateWR with it.
- pc  out  ADDR_W  current PC (debug/visibility).
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, IR=0, hence ins=4'b0000 and oper_addr=0; imem_rd=0, exec_en=0, halted=0. Reset asserted mid-fetch or mid-exec aborts immediately; any later imem_valid is ignored because the state is IDLE.
- States: IDLE, FETCH, DECODE, EXEC, HALT. All outputs are registered, except imem_addr=pc, ins and oper_addr, which are continuous from registers.
- IDLE: imem_rd=0. Goes to FETCH on the next edge when run=1.
- FETCH: imem_rd=1, imem_addr=pc. Stays while imem_valid=0 (arbitrary wait, no timeout). On imem_valid=1: IR<=imem_data, go to DECODE. imem_rd drops in the cycle after valid.
- DECODE: exactly one cycle so the combinational decoder settles on the new ins. exec_en=0.
- EXEC: exactly one cycle, exec_en=1. At the edge that leaves EXEC, the next state and PC are chosen in this priority order:
  1. stp=1: go to HALT; pc unchanged (points at the STP word).
  2. pcWR=1: pc <= oper_addr; go to FETCH.
  3. ins==4'b1001 (BAN) and acc_neg=1: pc <= oper_addr; go to FETCH.
  4. Otherwise: pc <= pc+1 modulo 2^ADDR_W (wraps from all-ones to 0); go to FETCH.
- stp and pcWR both high: stp wins; no PC update.
- BAN with acc_neg=0 falls through to rule 4 (pc+1).
- HALT: halted=1, imem_rd=0, exec_en=0. Sticky; only rst_n leaves HALT. run is ignored.
- run is sampled only in IDLE. Deasserting run after start has no effect.
- Latency per instruction = wait cycles + 3. Zero-wait memory (valid in the first FETCH cycle) gives 3 cycles/instruction: FETCH, DECODE, EXEC.
- exec_en is never high in two consecutive cycles.
- Undefined opcodes (1010–1111) still produce one EXEC cycle and pc+1, with no special handling.

Test Plan:
- Reset/idle: rst_n=0 then 1, run=0 for 10 cycles → pc=0, imem_rd=0, exec_en=0, halted=0, ins=0.
- Straight-line, zero-wait memory: mem[0..2] = 16'h5003 (ADD 3), 16'h1000 (COM), 16'h4000 (STP); run=1 → imem_rd at pc 0,1,2; exec_en pulses exactly 3 times, 3 cycles apart; then halted=1 with pc=2; halted stays 1 for 20 further cycles.
- Memory wait + mid-fetch reset: valid delayed 4 cycles → imem_rd stays high 5 cycles, IR loaded only on the valid cycle. Second run: assert rst_n=0 during FETCH → state IDLE and pc=0 immediately, before the next clock edge.
- Jumps: mem[0]=16'h8020 (JMP 0x20), decoder drives pcWR=1 → next imem_addr=0x20. BAN 0x40 with acc_neg=1 → pc=0x40. Same BAN with acc_neg=0 → pc=old pc+1.
- Priority: force stp=1 and pcWR=1 together in EXEC → HALT, pc unchanged.
- Wrap: with the fetch at 0xFF (ADDR_W=8) holding a non-jump instruction → next fetch address 0x00.
